// File: rtl/rob_feeder_pkg.sv
// Shared types and defaults for the ROB feeder and the reorder buffer it feeds.
package rob_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_WIN = 2'd2,
        ST_ACK      = 2'd3
    } state_t;

    localparam int DEF_PID_LEN  = 8;
    localparam int DEF_WORD_LEN = 8;
    localparam int DEF_ROB_SIZE = 8;

endpackage

// File: rtl/rob_feeder_if.sv
// Link-side packet handshake, ROB insert port and status bundle of the feeder.
interface rob_feeder_if #(
    parameter int p_WORD_LEN = 8,
    parameter int p_PID_LEN  = 8,
    parameter int p_CNT_LEN  = 16
);
    logic [p_PID_LEN-1:0]  pkt_pid;
    logic [p_WORD_LEN-1:0] pkt_data;
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [p_PID_LEN-1:0]  rob_pid;
    logic [p_WORD_LEN-1:0] rob_data;
    logic                  rob_en;
    logic                  rob_ack;
    logic [p_PID_LEN-1:0]  rob_min_pid;
    logic [p_CNT_LEN-1:0]  acc_cnt;
    logic [p_CNT_LEN-1:0]  drop_cnt;
    logic                  busy;

    // Environment side: link source plus the ROB.
    modport master (
        output pkt_pid, pkt_data, pkt_valid, rob_ack, rob_min_pid,
        input  pkt_ready, rob_pid, rob_data, rob_en, acc_cnt, drop_cnt, busy
    );

    // Feeder side.
    modport slave (
        input  pkt_pid, pkt_data, pkt_valid, rob_ack, rob_min_pid,
        output pkt_ready, rob_pid, rob_data, rob_en, acc_cnt, drop_cnt, busy
    );
endinterface

// File: rtl/rob_feeder_win.sv
// Combinational stale / in-window classification of a held PID against the ROB head.
module rob_feeder_win
    import rob_feeder_pkg::*;
#(
    parameter int p_PID_LEN  = DEF_PID_LEN,
    parameter int p_ROB_SIZE = DEF_ROB_SIZE
) (
    input  logic [p_PID_LEN-1:0] held_pid,
    input  logic [p_PID_LEN-1:0] min_pid,
    output logic                 stale,
    output logic                 in_win
);

    logic [p_PID_LEN-1:0] diff_s;

    // Stale uses a plain unsigned compare to match the ROB; distance is modular.
    always_comb begin
        diff_s = held_pid - min_pid;
        stale  = (held_pid < min_pid);
        in_win = !stale && (32'(diff_s) < 32'(p_ROB_SIZE));
    end

endmodule

// File: rtl/rob_feeder.sv
// Holds one link packet, inserts it into the ROB when it fits the window,
// retries NAKed inserts and drops stale or expired packets.
module rob_feeder
    import rob_feeder_pkg::*;
#(
    parameter int p_WORD_LEN   = DEF_WORD_LEN,
    parameter int p_PID_LEN    = DEF_PID_LEN,
    parameter int p_ROB_SIZE   = DEF_ROB_SIZE,
    parameter int p_MAX_RETRY  = 3,
    parameter int p_WAIT_LIMIT = 64,
    parameter int p_CNT_LEN    = 16
) (
    input  logic        clk,
    input  logic        rst,
    rob_feeder_if.slave bus
);

    localparam int RETRY_W = ($clog2(p_MAX_RETRY + 1) < 1) ? 1 : $clog2(p_MAX_RETRY + 1);
    localparam int WAIT_W  = ($clog2(p_WAIT_LIMIT) < 1) ? 1 : $clog2(p_WAIT_LIMIT);

    state_t                state_r, state_s;
    logic [p_PID_LEN-1:0]  pid_r;
    logic [p_WORD_LEN-1:0] data_r;
    logic [RETRY_W-1:0]    retry_r;
    logic [WAIT_W-1:0]     wait_r;
    logic [p_CNT_LEN-1:0]  acc_r, drop_r;
    logic                  stale_s, in_win_s;
    logic                  capture_s, inc_acc_s, inc_drop_s, inc_retry_s, inc_wait_s;

    rob_feeder_win #(
        .p_PID_LEN  (p_PID_LEN),
        .p_ROB_SIZE (p_ROB_SIZE)
    ) u_win (
        .held_pid (pid_r),
        .min_pid  (bus.rob_min_pid),
        .stale    (stale_s),
        .in_win   (in_win_s)
    );

    // Next-state and per-cycle counter strobes; at most one counter strobe fires.
    always_comb begin
        state_s     = state_r;
        capture_s   = 1'b0;
        inc_acc_s   = 1'b0;
        inc_drop_s  = 1'b0;
        inc_retry_s = 1'b0;
        inc_wait_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.pkt_valid) begin
                    capture_s = 1'b1;
                    state_s   = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (stale_s) begin
                    inc_drop_s = 1'b1;
                    state_s    = ST_IDLE;
                end else if (in_win_s) begin
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_WAIT_WIN;
                end
            end
            ST_WAIT_WIN: begin
                if (stale_s) begin
                    inc_drop_s = 1'b1;
                    state_s    = ST_IDLE;
                end else if (in_win_s) begin
                    state_s = ST_ISSUE;
                end else if (wait_r == WAIT_W'(p_WAIT_LIMIT - 1)) begin
                    inc_drop_s = 1'b1;
                    state_s    = ST_IDLE;
                end else begin
                    inc_wait_s = 1'b1;
                    state_s    = ST_WAIT_WIN;
                end
            end
            ST_ACK: begin
                if (bus.rob_ack) begin
                    inc_acc_s = 1'b1;
                    state_s   = ST_IDLE;
                end else if (retry_r == RETRY_W'(p_MAX_RETRY)) begin
                    inc_drop_s = 1'b1;
                    state_s    = ST_IDLE;
                end else begin
                    inc_retry_s = 1'b1;
                    state_s     = ST_ISSUE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Holding registers plus retry and window-wait counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pid_r   <= '0;
            data_r  <= '0;
            retry_r <= '0;
            wait_r  <= '0;
        end else if (capture_s) begin
            pid_r   <= bus.pkt_pid;
            data_r  <= bus.pkt_data;
            retry_r <= '0;
            wait_r  <= '0;
        end else begin
            if (inc_retry_s) retry_r <= retry_r + RETRY_W'(1);
            if (inc_wait_s)  wait_r  <= wait_r + WAIT_W'(1);
        end
    end

    // Wrapping status counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r  <= '0;
            drop_r <= '0;
        end else begin
            if (inc_acc_s)  acc_r  <= acc_r + p_CNT_LEN'(1);
            if (inc_drop_s) drop_r <= drop_r + p_CNT_LEN'(1);
        end
    end

    // The insert strobe is gated by the window so a stale ISSUE never reaches the ROB.
    assign bus.rob_en    = (state_r == ST_ISSUE) && in_win_s;
    assign bus.pkt_ready = (state_r == ST_IDLE);
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.rob_pid   = pid_r;
    assign bus.rob_data  = data_r;
    assign bus.acc_cnt   = acc_r;
    assign bus.drop_cnt  = drop_r;

endmodule

// File: tb/tb_rob_feeder.sv
// Directed table-driven bench for rob_feeder with hand-written window-wait and reset sequences.
module tb_rob_feeder;

    localparam int PID_LEN  = 8;
    localparam int WORD_LEN = 8;
    localparam int CNT_LEN  = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rob_feeder_if #(.p_WORD_LEN(WORD_LEN), .p_PID_LEN(PID_LEN), .p_CNT_LEN(CNT_LEN)) bus ();

    rob_feeder #(
        .p_WORD_LEN   (WORD_LEN),
        .p_PID_LEN    (PID_LEN),
        .p_ROB_SIZE   (8),
        .p_MAX_RETRY  (3),
        .p_WAIT_LIMIT (64),
        .p_CNT_LEN    (CNT_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] pid;
        logic [7:0] min_pid;
        int         ack_on;
        int         exp_pulses;
        int         exp_cycles;
        int         exp_acc;
        int         exp_drop;
    } vec_t;

    vec_t vecs [10];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_acc  = 0;
    int   exp_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one packet from IDLE, plays the ROB (ack one cycle after the selected strobe)
    // and returns once the feeder is ready again.
    task automatic run_pkt(input logic [7:0] pid, input logic [7:0] data, input int ack_on,
                           output int pulses, output int cycles);
        logic ack_pend;
        ack_pend      = 1'b0;
        pulses        = 0;
        cycles        = 0;
        bus.pkt_pid   = pid;
        bus.pkt_data  = data;
        bus.pkt_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            cycles++;
            bus.pkt_valid = 1'b0;
            bus.rob_ack   = ack_pend;
            ack_pend      = 1'b0;
            if (bus.rob_en) begin
                pulses++;
                check("en_pid", 32'(bus.rob_pid), 32'(pid));
                check("en_data", 32'(bus.rob_data), 32'(data));
                ack_pend = (pulses == ack_on);
            end
            if (bus.pkt_ready) break;
        end
        if (!bus.pkt_ready) check("ready_timeout", 32'(bus.pkt_ready), 32'd1);
        bus.rob_ack = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, cycles;

        //          pid     min     ack  pulses cycles acc drop
        vecs[0] = '{8'd3,   8'd0,   1,   1,     3,     1,  0};
        vecs[1] = '{8'd7,   8'd10,  1,   0,     2,     0,  1};
        vecs[2] = '{8'd10,  8'd10,  1,   1,     3,     1,  0};
        vecs[3] = '{8'd17,  8'd10,  1,   1,     3,     1,  0};
        vecs[4] = '{8'd18,  8'd10,  1,   0,     66,    0,  1};
        vecs[5] = '{8'd255, 8'd250, 1,   1,     3,     1,  0};
        vecs[6] = '{8'd2,   8'd250, 1,   0,     2,     0,  1};
        vecs[7] = '{8'd5,   8'd0,   0,   4,     9,     0,  1};
        vecs[8] = '{8'd6,   8'd0,   3,   3,     7,     1,  0};
        vecs[9] = '{8'd7,   8'd0,   4,   4,     9,     1,  0};

        rst             = 1'b1;
        bus.pkt_valid   = 1'b0;
        bus.pkt_pid     = 8'd0;
        bus.pkt_data    = 8'd0;
        bus.rob_ack     = 1'b0;
        bus.rob_min_pid = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.pkt_ready), 32'd1);
        check("rst_en", 32'(bus.rob_en), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_acc", 32'(bus.acc_cnt), 32'd0);
        check("rst_drop", 32'(bus.drop_cnt), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            bus.rob_min_pid = vecs[i].min_pid;
            run_pkt(vecs[i].pid, 8'hA5 ^ 8'(i), vecs[i].ack_on, pulses, cycles);
            exp_acc  += vecs[i].exp_acc;
            exp_drop += vecs[i].exp_drop;
            check($sformatf("v%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
            check($sformatf("v%0d_cycles", i), 32'(cycles), 32'(vecs[i].exp_cycles));
            check($sformatf("v%0d_acc", i), 32'(bus.acc_cnt), 32'(exp_acc));
            check($sformatf("v%0d_drop", i), 32'(bus.drop_cnt), 32'(exp_drop));
        end

        // Window wait: pid 9 is outside [0,8) until the ROB pops twice.
        bus.rob_min_pid = 8'd0;
        bus.pkt_pid     = 8'd9;
        bus.pkt_data    = 8'h3C;
        bus.pkt_valid   = 1'b1;
        step();
        bus.pkt_valid = 1'b0;
        check("ww_issue_en", 32'(bus.rob_en), 32'd0);
        step();
        check("ww_wait_busy", 32'(bus.busy), 32'd1);
        check("ww_wait_en0", 32'(bus.rob_en), 32'd0);
        bus.rob_min_pid = 8'd1;
        step();
        check("ww_wait_en1", 32'(bus.rob_en), 32'd0);
        bus.rob_min_pid = 8'd2;
        step();
        check("ww_issue_en_hi", 32'(bus.rob_en), 32'd1);
        check("ww_issue_pid", 32'(bus.rob_pid), 32'd9);
        step();
        bus.rob_ack = 1'b1;
        check("ww_ack_en", 32'(bus.rob_en), 32'd0);
        step();
        bus.rob_ack = 1'b0;
        exp_acc++;
        check("ww_ready", 32'(bus.pkt_ready), 32'd1);
        check("ww_acc", 32'(bus.acc_cnt), 32'(exp_acc));
        check("ww_drop", 32'(bus.drop_cnt), 32'(exp_drop));

        // Reset while the insert strobe is high: it must drop without a clock edge.
        bus.rob_min_pid = 8'd0;
        bus.pkt_pid     = 8'd4;
        bus.pkt_valid   = 1'b1;
        step();
        bus.pkt_valid = 1'b0;
        check("ri_pre_en", 32'(bus.rob_en), 32'd1);
        rst = 1'b1;
        #1;
        check("ri_en", 32'(bus.rob_en), 32'd0);
        check("ri_busy", 32'(bus.busy), 32'd0);
        check("ri_ready", 32'(bus.pkt_ready), 32'd1);
        check("ri_acc", 32'(bus.acc_cnt), 32'd0);
        check("ri_drop", 32'(bus.drop_cnt), 32'd0);
        rst = 1'b0;
        step();

        // Reset in ACK after one accepted packet.
        run_pkt(8'd1, 8'h11, 1, pulses, cycles);
        check("ra_acc_pre", 32'(bus.acc_cnt), 32'd1);
        bus.pkt_pid   = 8'd5;
        bus.pkt_valid = 1'b1;
        step();
        bus.pkt_valid = 1'b0;
        step();
        check("ra_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("ra_busy", 32'(bus.busy), 32'd0);
        check("ra_en", 32'(bus.rob_en), 32'd0);
        check("ra_ready", 32'(bus.pkt_ready), 32'd1);
        check("ra_acc", 32'(bus.acc_cnt), 32'd0);
        check("ra_drop", 32'(bus.drop_cnt), 32'd0);
        rst = 1'b0;
        step();

        run_pkt(8'd2, 8'h22, 1, pulses, cycles);
        check("post_rst_cycles", 32'(cycles), 32'd3);
        check("post_rst_acc", 32'(bus.acc_cnt), 32'd1);
        check("post_rst_drop", 32'(bus.drop_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
